// File: rtl/div_seq_pkg.sv
// Shared encodings and constants for the iterative divider and its EX-stage user.
package div_seq_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_seq_if.sv
// Request/response bundle between EX (master) and the divider (slave).
interface div_seq_if
  import div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle restoring divider: one quotient bit per cycle, {remainder, quotient} out.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic     clk,
  input  logic     rst,
  div_seq_if.slave bus
);

  localparam int unsigned WW = 2*WIDTH + 1;

  div_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [WW-1:0]      r_work, w_work_nxt;
  logic [WIDTH-1:0]   r_divisor, w_divisor_nxt;
  logic               r_neg_q, w_neg_q_nxt;
  logic               r_neg_r, w_neg_r_nxt;
  logic [2*WIDTH-1:0] r_result, w_result_nxt;
  logic               r_ready, w_ready_nxt;

  logic               w_sign1, w_sign2;
  logic [WIDTH-1:0]   w_abs1, w_abs2;
  logic [WIDTH+1:0]   w_diff;
  logic [WW-1:0]      w_step;
  logic [WIDTH-1:0]   w_quot, w_rem;

  // Operand magnitudes for signed requests
  assign w_sign1 = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
  assign w_sign2 = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
  assign w_abs1  = w_sign1 ? WIDTH'(-bus.opdata1_i) : bus.opdata1_i;
  assign w_abs2  = w_sign2 ? WIDTH'(-bus.opdata2_i) : bus.opdata2_i;

  // One restoring step on the upper WIDTH+1 bits; the window can exceed WIDTH bits
  assign w_diff = {1'b0, r_work[2*WIDTH:WIDTH]} - {2'b00, r_divisor};
  assign w_step = w_diff[WIDTH+1] ? {r_work[2*WIDTH-1:0], 1'b0}
                                  : WW'({w_diff[WIDTH:0], r_work[WIDTH-1:0], 1'b1});

  assign w_quot = r_neg_q ? WIDTH'(-w_step[WIDTH-1:0])       : w_step[WIDTH-1:0];
  assign w_rem  = r_neg_r ? WIDTH'(-w_step[2*WIDTH:WIDTH+1]) : w_step[2*WIDTH:WIDTH+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= DIV_FREE;
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= '0;
      r_ready   <= DIV_RESULT_NOT_READY;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_work    <= w_work_nxt;
      r_divisor <= w_divisor_nxt;
      r_neg_q   <= w_neg_q_nxt;
      r_neg_r   <= w_neg_r_nxt;
      r_result  <= w_result_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  // Completion is folded into the last step so the result lands WIDTH+1 edges after acceptance
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_work_nxt    = r_work;
    w_divisor_nxt = r_divisor;
    w_neg_q_nxt   = r_neg_q;
    w_neg_r_nxt   = r_neg_r;
    w_result_nxt  = r_result;
    w_ready_nxt   = r_ready;
    case (r_state)
      DIV_FREE: begin
        w_result_nxt = '0;
        w_ready_nxt  = DIV_RESULT_NOT_READY;
        if (bus.start_i == DIV_START && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            w_state_nxt = DIV_BYZERO;
          end else begin
            w_state_nxt   = DIV_ON;
            w_cnt_nxt     = '0;
            w_work_nxt    = {WIDTH'(0), w_abs1, 1'b0};
            w_divisor_nxt = w_abs2;
            w_neg_q_nxt   = w_sign1 ^ w_sign2;
            w_neg_r_nxt   = w_sign1;
          end
        end
      end
      DIV_BYZERO: begin
        w_state_nxt  = DIV_END;
        w_result_nxt = '0;
        w_ready_nxt  = DIV_RESULT_READY;
      end
      DIV_ON: begin
        if (bus.annul_i) begin
          w_state_nxt  = DIV_FREE;
          w_result_nxt = '0;
          w_ready_nxt  = DIV_RESULT_NOT_READY;
        end else begin
          w_work_nxt = w_step;
          w_cnt_nxt  = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH-1)) begin
            w_state_nxt  = DIV_END;
            w_result_nxt = {w_rem, w_quot};
            w_ready_nxt  = DIV_RESULT_READY;
          end
        end
      end
      DIV_END: begin
        if (bus.start_i == DIV_STOP || bus.annul_i) begin
          w_state_nxt  = DIV_FREE;
          w_result_nxt = '0;
          w_ready_nxt  = DIV_RESULT_NOT_READY;
        end
      end
      default: begin
        w_state_nxt = DIV_FREE;
      end
    endcase
  end

  assign bus.result_o = r_result;
  assign bus.ready_o  = r_ready;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboarded random/directed bench for div_seq against an arithmetic reference model.
module tb_div_seq;

  logic clk;
  logic rst;
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_pass;

  typedef struct {
    logic [63:0] res;
    int unsigned cyc;
    int unsigned lat;
  } exp_t;

  exp_t sb_q[$];

  div_seq_if bus ();

  div_seq u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    logic [31:0] q32, r32;
    if (b == 32'd0) return 64'd0;
    if (sd) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = longint'({32'd0, a});
      lb = longint'({32'd0, b});
    end
    q = la / lb;
    r = la % lb;
    q32 = q[31:0];
    r32 = r[31:0];
    return {r32, q32};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sd, input logic [31:0] a, input logic [31:0] b);
    bus.signed_div_i = sd;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
  endtask

  task automatic push(input logic sd, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.res = ref_div(sd, a, b);
    e.cyc = cyc;
    e.lat = (b == 32'd0) ? 2 : 33;
    sb_q.push_back(e);
  endtask

  // Wait for ready, hold start a little, then release and expect the idle state
  task automatic finish_req();
    int n;
    n = 0;
    while (bus.ready_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (bus.ready_o !== 1'b1) check("ready_timeout", {63'd0, bus.ready_o}, 64'd1);
    repeat ($urandom_range(0, 3)) tick();
    bus.start_i = 1'b0;
    bus.opdata1_i = $urandom;
    bus.opdata2_i = $urandom;
    tick();
    check("idle_after_drop", {bus.ready_o, bus.result_o[62:0]}, 64'd0);
    check("idle_result", bus.result_o, 64'd0);
  endtask

  task automatic do_div(input logic sd, input logic [31:0] a, input logic [31:0] b);
    drive(sd, a, b);
    push(sd, a, b);
    finish_req();
  endtask

  task automatic do_annul(input logic [31:0] a, input logic [31:0] b, input int wait_n);
    drive(1'b0, a, b);
    repeat (wait_n) tick();
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    tick();
    check("annul_ready", {63'd0, bus.ready_o}, 64'd0);
    check("annul_result", bus.result_o, 64'd0);
    bus.annul_i = 1'b0;
    repeat (40) tick();
  endtask

  initial begin
    logic        prev_ready;
    logic [63:0] held;
    cyc = 0;
    n_checks = 0;
    n_pass = 0;
    rst = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;

    // Monitor: pops the scoreboard on each rising ready and checks result and latency
    fork
      begin
        prev_ready = 1'b0;
        held = '0;
        forever begin
          @(negedge clk);
          if (bus.ready_o === 1'b1 && prev_ready !== 1'b1) begin
            if (sb_q.size() == 0) begin
              check("unexpected_ready", {63'd0, bus.ready_o}, 64'd0);
            end else begin
              exp_t e;
              e = sb_q.pop_front();
              check("result", bus.result_o, e.res);
              check("latency", 64'(cyc - e.cyc), 64'(e.lat));
            end
            held = bus.result_o;
          end else if (bus.ready_o === 1'b1) begin
            check("result_hold", bus.result_o, held);
          end
          prev_ready = bus.ready_o;
        end
      end
    join_none

    repeat (3) tick();
    check("reset_ready", {63'd0, bus.ready_o}, 64'd0);
    check("reset_result", bus.result_o, 64'd0);
    rst = 1'b0;
    tick();

    do_div(1'b0, 32'h0000_0064, 32'h0000_0007);
    check("ref_100_7", ref_div(1'b0, 32'h64, 32'h7), 64'h00000002_0000000E);
    do_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    do_div(1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
    do_div(1'b0, 32'h0000_1234, 32'h0000_0000);
    do_annul(32'hFFFF_FFFF, 32'h0000_0001, 11);
    do_div(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    do_annul(32'hFFFF_FFFF, 32'h0000_0003, 32);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);

    // Synchronous reset mid-operation with start held high
    drive(1'b0, 32'hDEAD_BEEF, 32'h0000_0013);
    repeat (15) tick();
    rst = 1'b1;
    tick();
    check("midrst_ready", {63'd0, bus.ready_o}, 64'd0);
    check("midrst_result", bus.result_o, 64'd0);
    rst = 1'b0;
    push(1'b0, 32'hDEAD_BEEF, 32'h0000_0013);
    finish_req();

    for (int i = 0; i < 24; i++) begin
      logic        sd;
      logic [31:0] a, b;
      sd = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'd0;
        default: b = $urandom | 32'h8000_0000;
      endcase
      do_div(sd, a, b);
    end

    repeat (3) tick();
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
